// File: rtl/byte_serial_pkg.sv
// Shared types and constants for the byte-serial transmitter.
// Optional parity support is selected with BYTE_SERIAL_TX_PARITY_EN.
package byte_serial_pkg;

  // Transmit FSM states. PARITY is only reached when parity is compiled in.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Serial line levels
  localparam logic TX_IDLE_LEVEL  = 1'b1;
  localparam logic TX_START_LEVEL = 1'b0;

  // Even parity over one data byte: the bit that makes the total count of ones even
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/byte_serial_tx_sync_fifo.sv
// Synchronous FIFO with registered storage and a combinational head output.
// The caller guarantees push only when not full (or when popping in the same
// cycle) and pop only when not empty.
module sync_fifo
  import byte_serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage write; no reset needed, validity is tracked by count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/byte_serial_tx.sv
// Byte-serial UART-style transmitter fed by upstream byte bursts.
// Bytes are queued in a FIFO and sent LSB-first as start/8 data/stop frames.
// Define BYTE_SERIAL_TX_PARITY_EN to insert an even-parity bit before stop.
module byte_serial_tx
  import byte_serial_pkg::*;
#(
  parameter int DEPTH        = 32,
  parameter int BURST_MAX    = 16,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Din,
  input  logic       i_valid,
  output logic       busy,
  output logic       tx,
  output logic       tx_active,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_START = START;
  localparam logic [2:0] S_DATA  = DATA;
  localparam logic [2:0] S_STOP  = STOP;

  logic [2:0]    state;
  logic [BW-1:0] baud;
  logic [2:0]    bitcnt;
  logic [7:0]    shift;
  logic          baud_wrap;
  logic          push;
  logic          pop;
  logic          line_level;
  logic [7:0]    head;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic [AW:0]   nxt_count;
`ifdef BYTE_SERIAL_TX_PARITY_EN
  logic          par;
`endif

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (Din),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign baud_wrap = (baud == BW'(CLKS_PER_BIT - 1));

  // Fetch a new byte when idle, or at the very end of a stop bit so frames
  // run back-to-back without an idle gap.
  assign pop = !empty && ((state == S_IDLE) || ((state == S_STOP) && baud_wrap));

  // A full FIFO still accepts a byte if the head leaves in the same cycle
  assign push = i_valid && (!full || pop);

  assign nxt_count = count + (AW+1)'(push) - (AW+1)'(pop);

  // Level the current state wants on the line; registered into tx below
  always_comb begin
    line_level = TX_IDLE_LEVEL;
    case (state)
      S_START: line_level = TX_START_LEVEL;
      S_DATA:  line_level = shift[0];
`ifdef BYTE_SERIAL_TX_PARITY_EN
      PARITY:  line_level = par;
`endif
      default: line_level = TX_IDLE_LEVEL;
    endcase
  end

  // Frame sequencer: state, baud counter, bit counter and shift register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      baud   <= '0;
      bitcnt <= '0;
      shift  <= '0;
`ifdef BYTE_SERIAL_TX_PARITY_EN
      par    <= 1'b0;
`endif
    end else if (state == S_IDLE) begin
      baud   <= '0;
      bitcnt <= '0;
      if (pop) begin
        shift <= head;
`ifdef BYTE_SERIAL_TX_PARITY_EN
        par   <= even_parity(head);
`endif
        state <= S_START;
      end
    end else if (!baud_wrap) begin
      baud <= baud + 1'b1;
    end else begin
      baud <= '0;
      case (state)
        S_START: begin
          bitcnt <= '0;
          state  <= S_DATA;
        end
        S_DATA: begin
          shift  <= shift >> 1;
          bitcnt <= bitcnt + 1'b1;
          if (bitcnt == 3'd7) begin
`ifdef BYTE_SERIAL_TX_PARITY_EN
            state <= PARITY;
`else
            state <= S_STOP;
`endif
          end
        end
`ifdef BYTE_SERIAL_TX_PARITY_EN
        PARITY: state <= S_STOP;
`endif
        S_STOP: begin
          if (pop) begin
            shift <= head;
`ifdef BYTE_SERIAL_TX_PARITY_EN
            par   <= even_parity(head);
`endif
            state <= S_START;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Registered line outputs; they trail the state by one cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx        <= TX_IDLE_LEVEL;
      tx_active <= 1'b0;
    end else begin
      tx        <= line_level;
      tx_active <= (state != S_IDLE);
    end
  end

  // Back-pressure from the post-update count, plus sticky drop flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      busy     <= (nxt_count > (AW+1)'(DEPTH - BURST_MAX));
      overflow <= overflow | (i_valid && !push);
    end
  end

endmodule

// File: tb/tb_byte_serial_tx.sv
// Testbench for byte_serial_tx: two instances (4 and 64 clocks per bit) are
// checked every cycle against a queue-based model of the FIFO and line, plus
// literal frame patterns worked out by hand.
module tb_byte_serial_tx;

  localparam int DEPTH = 32;
  localparam int BMAX  = 16;
`ifdef BYTE_SERIAL_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int F0 = NBITS * 4;
  localparam int F1 = NBITS * 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b0, rst1 = 1'b0;
  logic       vld0 = 1'b0, vld1 = 1'b0;
  logic [7:0] din0 = '0,   din1 = '0;
  logic       busy0, tx0, act0, ovf0;
  logic       busy1, tx1, act1, ovf1;

  byte_serial_tx #(.DEPTH(DEPTH), .BURST_MAX(BMAX), .CLKS_PER_BIT(4)) u_dut0 (
    .clk(clk), .reset(rst0), .Din(din0), .i_valid(vld0),
    .busy(busy0), .tx(tx0), .tx_active(act0), .overflow(ovf0));

  byte_serial_tx #(.DEPTH(DEPTH), .BURST_MAX(BMAX), .CLKS_PER_BIT(64)) u_dut1 (
    .clk(clk), .reset(rst1), .Din(din1), .i_valid(vld1),
    .busy(busy1), .tx(tx1), .tx_active(act1), .overflow(ovf1));

  int total = 0;
  int bad   = 0;
  int t     = 0;

  // Model state per instance
  logic [7:0] mq [2][$];
  bit         lq [2][$];
  int         free_at [2];
  bit         e_tx [2], e_act [2], e_busy [2], e_ovf [2];

  task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%0h want=%0h cycle=%0d", nm, g, act, exp, t);
    end
  endtask

  // Advance one clock: update the model from the inputs seen at the edge,
  // then check all outputs of both instances just after the edge.
  task automatic tick();
    logic r, v, b, lvl;
    logic [7:0] d;
    int cpb;
    @(posedge clk);
    for (int g = 0; g < 2; g++) begin
      if (g == 0) begin r = rst0; v = vld0; d = din0; cpb = 4;  end
      else        begin r = rst1; v = vld1; d = din1; cpb = 64; end
      if (!r) begin
        mq[g].delete(); lq[g].delete(); free_at[g] = 0;
        e_tx[g] = 1'b1; e_act[g] = 1'b0; e_busy[g] = 1'b1; e_ovf[g] = 1'b0;
      end else begin
        if (lq[g].size() > 0) begin e_tx[g] = lq[g].pop_front(); e_act[g] = 1'b1; end
        else                  begin e_tx[g] = 1'b1;              e_act[g] = 1'b0; end
        b = (t >= free_at[g]) && (mq[g].size() > 0);
        if (b) begin
          d = (g == 0) ? din0 : din1;
          begin
            logic [7:0] hb;
            hb = mq[g].pop_front();
            for (int k = 0; k < NBITS; k++) begin
              if (k == 0)          lvl = 1'b0;
              else if (k <= 8)     lvl = hb[k-1];
              else if (k == NBITS-1) lvl = 1'b1;
              else                 lvl = ^hb;
              for (int c = 0; c < cpb; c++) lq[g].push_back(lvl);
            end
          end
          free_at[g] = t + NBITS * cpb;
        end
        if (v) begin
          if (mq[g].size() < DEPTH) mq[g].push_back(d);
          else e_ovf[g] = 1'b1;
        end
        e_busy[g] = (mq[g].size() > DEPTH - BMAX);
      end
    end
    t++;
    #1;
    chk("tx",       0, 64'(tx0),   64'(e_tx[0]));
    chk("tx_active",0, 64'(act0),  64'(e_act[0]));
    chk("busy",     0, 64'(busy0), 64'(e_busy[0]));
    chk("overflow", 0, 64'(ovf0),  64'(e_ovf[0]));
    chk("tx",       1, 64'(tx1),   64'(e_tx[1]));
    chk("tx_active",1, 64'(act1),  64'(e_act[1]));
    chk("busy",     1, 64'(busy1), 64'(e_busy[1]));
    chk("overflow", 1, 64'(ovf1),  64'(e_ovf[1]));
  endtask

  // Push one byte on instance 0 and capture the line for one full frame
  task automatic send0(input logic [7:0] b, output logic [63:0] frame, output int acnt);
    frame = '0; acnt = 0;
    din0 = b; vld0 = 1'b1; tick();
    vld0 = 1'b0; tick();
    chk("tx_before_start", 0, 64'(tx0), 64'd1);
    for (int i = 0; i < F0; i++) begin
      tick();
      frame = {frame[62:0], tx0};
      if (act0) acnt++;
    end
  endtask

  initial begin
    logic [63:0] frame;
    int acnt, run, maxrun;

    // Reset
    repeat (3) tick();
    chk("rst_busy", 0, 64'(busy0), 64'd1);
    chk("rst_tx",   1, 64'(tx1),   64'd1);
    rst0 = 1'b1; rst1 = 1'b1;
    tick();
    chk("post_rst_busy", 0, 64'(busy0), 64'd0);
    chk("post_rst_tx",   0, 64'(tx0),   64'd1);
    chk("post_rst_ovf",  0, 64'(ovf0),  64'd0);
    chk("post_rst_act",  0, 64'(act0),  64'd0);
    chk("post_rst_busy", 1, 64'(busy1), 64'd0);
    repeat (3) tick();

    // Single byte A5
    send0(8'hA5, frame, acnt);
`ifdef BYTE_SERIAL_TX_PARITY_EN
    chk("frame_a5", 0, frame & 64'hFFF_FFFF_FFFF, 64'h0F0F00F0F0F);
`else
    chk("frame_a5", 0, frame & 64'hFF_FFFF_FFFF, 64'h0F0F00F0FF);
`endif
    chk("frame_a5_len", 0, 64'(acnt), 64'(F0));
    repeat (5) tick();

    // 16-byte burst 0F..00, drained back-to-back
    run = 0; maxrun = 0;
    for (int i = 0; i < 16; i++) begin
      din0 = 8'h0F - 8'(i); vld0 = 1'b1; tick();
      chk("burst_busy", 0, 64'(busy0), 64'd0);
      if (act0) run++;
    end
    vld0 = 1'b0;
    for (int i = 0; i < 16 * F0 + 20; i++) begin
      tick();
      if (act0) run++;
      else begin if (run > maxrun) maxrun = run; run = 0; end
    end
    chk("burst_run", 0, 64'(maxrun), 64'(16 * F0));

    // Overflow on the slow instance: a frame in flight, then 33 pushes
    acnt = 0;
    din1 = 8'hC3; vld1 = 1'b1; tick();
    for (int i = 0; i < 33; i++) begin
      din1 = 8'(i); vld1 = 1'b1; tick();
      if (act1) acnt++;
      if (i == 15) chk("busy_at_16", 1, 64'(busy1), 64'd0);
      if (i == 16) chk("busy_at_17", 1, 64'(busy1), 64'd1);
      if (i == 31) chk("ovf_before", 1, 64'(ovf1),  64'd0);
      if (i == 32) chk("ovf_set",    1, 64'(ovf1),  64'd1);
    end
    vld1 = 1'b0;
    for (int i = 0; i < 33 * F1; i++) begin
      tick();
      if (act1) acnt++;
    end
    chk("ovf_sticky",  1, 64'(ovf1), 64'd1);
    chk("ovf_frames",  1, 64'(acnt), 64'(33 * F1));

    // Reset in the middle of data bit 3 of FF, with another FF queued
    din0 = 8'hFF; vld0 = 1'b1; tick();
    tick();
    vld0 = 1'b0;
    repeat (17) tick();
    chk("mid_bit3_tx",  0, 64'(tx0),  64'd1);
    chk("mid_bit3_act", 0, 64'(act0), 64'd1);
    rst0 = 1'b0; tick();
    chk("abort_tx",  0, 64'(tx0),  64'd1);
    chk("abort_act", 0, 64'(act0), 64'd0);
    rst0 = 1'b1;
    acnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (act0) acnt++;
    end
    chk("abort_no_frames", 0, 64'(acnt), 64'd0);

`ifdef BYTE_SERIAL_TX_PARITY_EN
    // Parity frame for 07: three ones, parity bit 1
    send0(8'h07, frame, acnt);
    chk("frame_07", 0, frame & 64'hFFF_FFFF_FFFF, 64'h0FFF00000FF);
    chk("frame_07_len", 0, 64'(acnt), 64'd44);
`endif

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
